// File: rtl/sorting_pkg.sv
// Shared types and helpers for the insertion-sort packet core.
package sorting_pkg;

  typedef enum logic [1:0] {
    LOAD_IDLE = 2'd0,
    LOAD      = 2'd1,
    UNLOAD    = 2'd2
  } state_e;

  // Widest data word the compare helper handles; narrower words are zero-extended.
  localparam int CMP_W = 64;

  // Count and read index must represent 0..max_len inclusive.
  function automatic int count_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // True when the stored word must move above the incoming word.
  // Strict compare keeps equal words in arrival order (stable sort).
  function automatic logic goes_after(input logic [CMP_W-1:0] slot_val,
                                      input logic [CMP_W-1:0] new_val,
                                      input logic             descending);
    return descending ? (slot_val < new_val) : (slot_val > new_val);
  endfunction

endpackage

// File: rtl/sorting_insertion_cell.sv
// One slot of the insertion-sort array: storage plus its compare against the incoming word.
module sorting_insertion_cell
  import sorting_pkg::*;
#(
  parameter int DWIDTH     = 4,
  parameter int DESCENDING = 0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] new_data_i,
  input  logic [DWIDTH-1:0] prev_data_i,
  input  logic              load_new_i,
  input  logic              shift_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              gt_o
);

  logic [DWIDTH-1:0] data_q;
  logic [DWIDTH-1:0] data_d;

  // Insert the new word here, take the lower neighbour's word, or hold.
  always_comb begin
    data_d = data_q;
    if (load_new_i) begin
      data_d = new_data_i;
    end else if (shift_i) begin
      data_d = prev_data_i;
    end
  end

  // Slot storage; cleared on reset only so simulation starts from known values.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
  assign gt_o   = goes_after(CMP_W'(data_q), CMP_W'(new_data_i), DESCENDING != 0);

endmodule

// File: rtl/sorting_insertion.sv
// Avalon-ST packet sorter: parallel insertion sort on load, in-order readout on unload.
// Optional overflow/framing-error pulse output ovf_o is enabled by SORTING_INSERTION_OVF_EN.
module sorting_insertion
  import sorting_pkg::*;
#(
  parameter int DWIDTH      = 4,
  parameter int MAX_PKT_LEN = 64,
  parameter int DESCENDING  = 0
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i
`ifdef SORTING_INSERTION_OVF_EN
  ,
  output logic              ovf_o
`endif
);

  localparam int CW = count_width(MAX_PKT_LEN);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_LEN);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic              snk_ready_q, snk_ready_d;

  logic [DWIDTH-1:0] slot_data [MAX_PKT_LEN];
  logic [MAX_PKT_LEN-1:0] gt;
  logic [MAX_PKT_LEN-1:0] load_new;
  logic [MAX_PKT_LEN-1:0] shift;
  logic [DWIDTH-1:0] rd_word;

  logic snk_fire, src_fire, restart, store_word;

  assign snk_fire = snk_valid_i & snk_ready_q;
  assign src_fire = src_valid_o & src_ready_i;

  // Next-state logic: packet framing, count update and readout sequencing.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_idx_d   = rd_idx_q;
    restart    = 1'b0;
    store_word = 1'b0;
    case (state_q)
      LOAD_IDLE: begin
        rd_idx_d = '0;
        if (snk_fire && snk_startofpacket_i) begin
          restart = 1'b1;
          count_d = CW'(1);
          state_d = snk_endofpacket_i ? UNLOAD : LOAD;
        end
      end
      LOAD: begin
        rd_idx_d = '0;
        if (snk_fire) begin
          if (snk_startofpacket_i) begin
            // A new sop mid-packet abandons the partial packet.
            restart = 1'b1;
            count_d = CW'(1);
          end else if (count_q != MAX_CNT) begin
            store_word = 1'b1;
            count_d    = count_q + CW'(1);
          end
          if (snk_endofpacket_i) begin
            state_d = UNLOAD;
          end
        end
      end
      UNLOAD: begin
        if (src_fire) begin
          if (rd_idx_q == count_q - CW'(1)) begin
            state_d = LOAD_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD_IDLE;
    endcase
    snk_ready_d = (state_d != UNLOAD);
  end

  // Control state registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= LOAD_IDLE;
      count_q     <= '0;
      rd_idx_q    <= '0;
      snk_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_idx_q    <= rd_idx_d;
      snk_ready_q <= snk_ready_d;
    end
  end

  // Insertion point is the first live slot that must move up, else slot count;
  // everything from there up to slot count shifts up by one.
  always_comb begin : ins_ctrl
    logic seen;
    logic hit;
    seen     = 1'b0;
    hit      = 1'b0;
    load_new = '0;
    shift    = '0;
    for (int i = 0; i < MAX_PKT_LEN; i++) begin
      hit         = ((CW'(i) < count_q) & gt[i]) | (CW'(i) == count_q);
      load_new[i] = store_word & hit & ~seen;
      shift[i]    = store_word & seen & (CW'(i) <= count_q);
      seen        = seen | hit;
    end
    load_new[0] = load_new[0] | restart;
  end

  generate
    for (genvar gi = 0; gi < MAX_PKT_LEN; gi++) begin : g_cell
      logic [DWIDTH-1:0] prev_data;
      if (gi == 0) begin : g_first
        assign prev_data = '0;
      end else begin : g_rest
        assign prev_data = slot_data[gi-1];
      end
      sorting_insertion_cell #(
        .DWIDTH     (DWIDTH),
        .DESCENDING (DESCENDING)
      ) u_cell (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .new_data_i  (snk_data_i),
        .prev_data_i (prev_data),
        .load_new_i  (load_new[gi]),
        .shift_i     (shift[gi]),
        .data_o      (slot_data[gi]),
        .gt_o        (gt[gi])
      );
    end
  endgenerate

  // Readout mux over the slot array, indexed by the read pointer.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < MAX_PKT_LEN; i++) begin
      if (CW'(i) == rd_idx_q) begin
        rd_word = slot_data[i];
      end
    end
  end

  assign snk_ready_o         = snk_ready_q;
  assign src_valid_o         = (state_q == UNLOAD);
  assign src_data_o          = src_valid_o ? rd_word : '0;
  assign src_startofpacket_o = src_valid_o & (rd_idx_q == '0);
  assign src_endofpacket_o   = src_valid_o & (rd_idx_q == count_q - CW'(1));

`ifdef SORTING_INSERTION_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_seen_q, ovf_seen_d;
  logic discard;

  assign discard = snk_fire & (state_q == LOAD) & ~snk_startofpacket_i & (count_q == MAX_CNT);

  // Flag the first dropped overflow word of a packet and any mid-packet restart.
  always_comb begin
    ovf_d      = 1'b0;
    ovf_seen_d = ovf_seen_q;
    if (restart) begin
      ovf_seen_d = 1'b0;
    end
    if (discard && !ovf_seen_q) begin
      ovf_d      = 1'b1;
      ovf_seen_d = 1'b1;
    end
    if (restart && (state_q == LOAD)) begin
      ovf_d = 1'b1;
    end
  end

  // Single-cycle error pulse register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_q      <= 1'b0;
      ovf_seen_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      ovf_seen_q <= ovf_seen_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_sorting_insertion.sv
// Scoreboard bench for sorting_insertion: three instances (ascending, descending,
// ascending with a 4-word limit) driven by directed and random packets.
module tb_sorting_insertion;

  localparam int NDUT = 3;
  localparam int DW   = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] snk_data [NDUT];
  logic          snk_sop [NDUT];
  logic          snk_eop [NDUT];
  logic          snk_valid [NDUT];
  logic          snk_ready [NDUT];
  logic [DW-1:0] src_data [NDUT];
  logic          src_sop [NDUT];
  logic          src_eop [NDUT];
  logic          src_valid [NDUT];
  logic          src_ready [NDUT];
  logic          ovf [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  exp_t          exp_q [NDUT][$];
  logic [DW-1:0] pkt_q [NDUT][$];
  bit            in_pkt [NDUT];
  bit            ovf_flag [NDUT];
  int            ovf_exp [NDUT];
  int            ovf_cnt [NDUT];
  int            bp_mode [NDUT];
  int            pat_idx [NDUT];

  generate
    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      sorting_insertion #(
        .DWIDTH      (DW),
        .MAX_PKT_LEN ((gi == 2) ? 4 : 8),
        .DESCENDING  ((gi == 1) ? 1 : 0)
      ) u_dut (
        .clk_i               (clk),
        .arst_i              (arst),
        .snk_data_i          (snk_data[gi]),
        .snk_startofpacket_i (snk_sop[gi]),
        .snk_endofpacket_i   (snk_eop[gi]),
        .snk_valid_i         (snk_valid[gi]),
        .snk_ready_o         (snk_ready[gi]),
        .src_data_o          (src_data[gi]),
        .src_startofpacket_o (src_sop[gi]),
        .src_endofpacket_o   (src_eop[gi]),
        .src_valid_o         (src_valid[gi]),
        .src_ready_i         (src_ready[gi])
`ifdef SORTING_INSERTION_OVF_EN
        ,
        .ovf_o               (ovf[gi])
`endif
      );
`ifndef SORTING_INSERTION_OVF_EN
      assign ovf[gi] = 1'b0;
`endif
    end
  endgenerate

  function automatic int max_of(input int d);
    return (d == 2) ? 4 : 8;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: packet framing rules, then a plain sort of the kept words.
  function automatic void model_accept(input int d, input logic [DW-1:0] data,
                                       input bit sop, input bit eop, output bit emitted);
    logic [DW-1:0] s [$];
    exp_t e;
    bit kept;
    emitted = 1'b0;
    kept    = 1'b1;
    if (sop) begin
      if (in_pkt[d]) ovf_exp[d]++;
      pkt_q[d].delete();
      pkt_q[d].push_back(data);
      in_pkt[d]   = 1'b1;
      ovf_flag[d] = 1'b0;
    end else if (!in_pkt[d]) begin
      kept = 1'b0;
    end else if (pkt_q[d].size() < max_of(d)) begin
      pkt_q[d].push_back(data);
    end else if (!ovf_flag[d]) begin
      ovf_flag[d] = 1'b1;
      ovf_exp[d]++;
    end
    if (kept && eop) begin
      s = pkt_q[d];
      if (d == 1) s.rsort(); else s.sort();
      for (int i = 0; i < s.size(); i++) begin
        e.data = s[i];
        e.sop  = (i == 0);
        e.eop  = (i == s.size() - 1);
        exp_q[d].push_back(e);
      end
      in_pkt[d] = 1'b0;
      emitted   = 1'b1;
    end
  endfunction

  task automatic drive_word(input int d, input logic [DW-1:0] data, input bit sop, input bit eop);
    int n;
    bit emitted;
    @(negedge clk);
    snk_data[d]  = data;
    snk_sop[d]   = sop;
    snk_eop[d]   = eop;
    snk_valid[d] = 1'b1;
    n = 0;
    while (snk_ready[d] !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (snk_ready[d] !== 1'b1) begin
      check("snk_ready_wait", snk_ready[d], 1);
      snk_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(d, data, sop, eop, emitted);
    #1;
    snk_valid[d] = 1'b0;
    snk_sop[d]   = 1'b0;
    snk_eop[d]   = 1'b0;
    if (emitted) begin
      @(negedge clk);
      check("src_valid_latency", src_valid[d], 1);
      check("snk_ready_in_unload", snk_ready[d], 0);
    end
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", exp_q[d].size(), 0);
  endtask

  task automatic send_pkt(input int d, input logic [DW-1:0] vals [$]);
    for (int i = 0; i < vals.size(); i++) begin
      drive_word(d, vals[i], i == 0, i == vals.size() - 1);
    end
    wait_drain(d);
  endtask

  // Monitor: sets backpressure, then compares every presented word with the queue head.
  initial begin : monitor
    int pat [4];
    exp_t e;
    pat = '{1, 0, 0, 1};
    for (int d = 0; d < NDUT; d++) src_ready[d] = 1'b1;
    forever begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        case (bp_mode[d])
          0:       src_ready[d] = 1'b1;
          1:       src_ready[d] = 1'($urandom_range(0, 1));
          2:       src_ready[d] = 1'b0;
          default: begin
            src_ready[d] = 1'(pat[pat_idx[d]]);
            pat_idx[d]   = (pat_idx[d] + 1) % 4;
          end
        endcase
        if (ovf[d] === 1'b1) ovf_cnt[d]++;
        if (!arst && src_valid[d] === 1'b1) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("unexpected_word[%0d]", d), src_valid[d], 0);
          end else begin
            e = exp_q[d][0];
            check($sformatf("src_data[%0d]", d), src_data[d], e.data);
            check($sformatf("src_sop[%0d]", d), src_sop[d], e.sop);
            check($sformatf("src_eop[%0d]", d), src_eop[d], e.eop);
            check($sformatf("snk_ready_busy[%0d]", d), snk_ready[d], 0);
            if (src_ready[d]) void'(exp_q[d].pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] vals [$];
    int d, len, junk;
    bit sop;
    for (int i = 0; i < NDUT; i++) begin
      snk_data[i] = '0; snk_sop[i] = 0; snk_eop[i] = 0; snk_valid[i] = 0;
      bp_mode[i] = 0; pat_idx[i] = 0; ovf_exp[i] = 0; ovf_cnt[i] = 0;
      in_pkt[i] = 0; ovf_flag[i] = 0;
    end
    #1 arst = 1'b1;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check("reset_src_valid", src_valid[i], 0);
      check("reset_src_data", src_data[i], 0);
      check("reset_src_sop", src_sop[i], 0);
      check("reset_src_eop", src_eop[i], 0);
      check("reset_snk_ready", snk_ready[i], 0);
    end
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    check("ready_before_edge", snk_ready[0], 0);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) check("ready_after_edge", snk_ready[i], 1);

    // Ascending basic packet
    vals = {4'd5, 4'd3, 4'd9, 4'd3, 4'd0};
    send_pkt(0, vals);
    // Descending packet and single-word packet
    vals = {4'd1, 4'd7, 4'd2};
    send_pkt(1, vals);
    vals = {4'd6};
    send_pkt(1, vals);
    // Overflow on the 4-word instance
    vals = {4'd8, 4'd1, 4'd5, 4'd2, 4'd0, 4'd9};
    send_pkt(2, vals);
    // Backpressure pattern 1,0,0,1
    bp_mode[0] = 3;
    vals = {4'd4, 4'd1, 4'd3, 4'd2};
    send_pkt(0, vals);
    bp_mode[0] = 0;
    // Idle words dropped, then mid-packet restart
    drive_word(0, 4'd7, 0, 0);
    drive_word(0, 4'd5, 0, 1);
    drive_word(0, 4'd4, 1, 0);
    drive_word(0, 4'd2, 0, 0);
    drive_word(0, 4'd3, 1, 0);
    drive_word(0, 4'd1, 0, 1);
    wait_drain(0);

    // Reset while unloading
    bp_mode[0] = 2;
    vals = {4'd5, 4'd6, 4'd7};
    for (int i = 0; i < vals.size(); i++) drive_word(0, vals[i], i == 0, i == 2);
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("arst_src_valid", src_valid[0], 0);
    check("arst_src_data", src_data[0], 0);
    check("arst_src_sop", src_sop[0], 0);
    check("arst_src_eop", src_eop[0], 0);
    check("arst_snk_ready", snk_ready[0], 0);
    for (int i = 0; i < NDUT; i++) begin
      exp_q[i].delete();
      in_pkt[i] = 1'b0;
    end
    @(negedge clk);
    arst = 1'b0;
    bp_mode[0] = 0;
    @(negedge clk);
    check("ready_after_arst", snk_ready[0], 1);
    vals = {4'd2, 4'd1};
    send_pkt(0, vals);

    // Random packets with junk words, gaps, restarts and backpressure
    for (int p = 0; p < 45; p++) begin
      d = $urandom_range(0, NDUT - 1);
      bp_mode[d] = ($urandom_range(0, 2) == 2) ? 3 : $urandom_range(0, 1);
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) drive_word(d, 4'($urandom_range(0, 15)), 0, 1'($urandom_range(0, 1)));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        sop = (i == 0) || ((i != len - 1) && ($urandom_range(0, 15) == 0));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        drive_word(d, 4'($urandom_range(0, 15)), sop, i == len - 1);
      end
      wait_drain(d);
      bp_mode[d] = 0;
    end

    repeat (3) @(negedge clk);
`ifdef SORTING_INSERTION_OVF_EN
    for (int i = 0; i < NDUT; i++) check($sformatf("ovf_pulses[%0d]", i), ovf_cnt[i], ovf_exp[i]);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
